// File: rtl/des_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : des_block_loader
// Description : Packs a plaintext byte stream into 64-bit DES blocks, holds
//               the round key, launches the core and watches for a hang.
// Revision    : 1.0 - initial release
// ============================================================================
module des_block_loader #(
    parameter logic [7:0]  PAD_BYTE = 8'h00,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic [63:0] key_in,
    input  logic        key_load,
    output logic [63:0] plain_text,
    output logic [63:0] key_out,
    output logic        start,
    input  logic        core_valid,
    output logic        busy,
    output logic [15:0] blk_count,
    output logic        timeout_err
);

    localparam int unsigned           C_WD_W    = $clog2(TIMEOUT);
    localparam logic [C_WD_W-1:0]     C_WD_LAST = C_WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [63:0]         plain_q, plain_d;
    logic [63:0]         key_q, key_d;
    logic [63:0]         key_pend_q, key_pend_d;
    logic                key_pending_q, key_pending_d;
    logic                start_q, start_d;
    logic [15:0]         blk_q, blk_d;
    logic                terr_q, terr_d;
    logic [C_WD_W-1:0]   wd_q, wd_d;
    logic                w_accept;

    assign s_ready     = (state_q == S_FILL);
    assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign w_accept    = s_valid && s_ready;
    assign plain_text  = plain_q;
    assign key_out     = key_q;
    assign start       = start_q;
    assign blk_count   = blk_q;
    assign timeout_err = terr_q;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        plain_d       = plain_q;
        key_d         = key_q;
        key_pend_d    = key_pend_q;
        key_pending_d = key_pending_q;
        start_d       = 1'b0;
        blk_d         = blk_q;
        terr_d        = terr_q;
        wd_d          = wd_q;

        case (state_q)
            S_FILL: begin
                if (key_load) begin
                    key_d         = key_in;
                    key_pending_d = 1'b0;
                end
                if (w_accept) begin
                    // First byte of a block pre-fills the rest with padding.
                    if (byte_cnt_q == 3'd0) begin
                        plain_d = {8{PAD_BYTE}};
                    end
                    for (int i = 0; i < 8; i++) begin
                        if (byte_cnt_q == 3'(i)) begin
                            plain_d[63-8*i -: 8] = s_data;
                        end
                    end
                    if (s_last || (byte_cnt_q == 3'd7)) begin
                        byte_cnt_d = 3'd0;
                        state_d    = S_LAUNCH;
                        start_d    = 1'b1;
                        blk_d      = blk_q + 16'd1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end

            S_LAUNCH: begin
                if (key_load) begin
                    key_pend_d    = key_in;
                    key_pending_d = 1'b1;
                end
                wd_d    = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (key_load) begin
                    key_pend_d    = key_in;
                    key_pending_d = 1'b1;
                end
                if (core_valid || (wd_q == C_WD_LAST)) begin
                    state_d = S_FILL;
                    if (!core_valid) begin
                        terr_d = 1'b1;
                    end
                    // A key strobed on the exit cycle is the newest one, so it wins.
                    if (key_load) begin
                        key_d = key_in;
                    end else if (key_pending_q) begin
                        key_d = key_pend_q;
                    end
                    key_pending_d = 1'b0;
                end else begin
                    wd_d = wd_q + C_WD_W'(1);
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            byte_cnt_q    <= 3'd0;
            plain_q       <= 64'd0;
            key_q         <= 64'd0;
            key_pend_q    <= 64'd0;
            key_pending_q <= 1'b0;
            start_q       <= 1'b0;
            blk_q         <= 16'd0;
            terr_q        <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            plain_q       <= plain_d;
            key_q         <= key_d;
            key_pend_q    <= key_pend_d;
            key_pending_q <= key_pending_d;
            start_q       <= start_d;
            blk_q         <= blk_d;
            terr_q        <= terr_d;
            wd_q          <= wd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_block_loader
// Description : Self-checking bench: directed vector table, corner sequences
//               and a randomized stream against a block-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_block_loader;

    localparam logic [7:0] PAD = 8'h00;
    localparam int         TMO = 64;
    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] K3 = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [63:0] key_in = 64'd0;
    logic        key_load = 1'b0;
    logic [63:0] plain_text;
    logic [63:0] key_out;
    logic        start;
    logic        core_valid = 1'b0;
    logic        busy;
    logic [15:0] blk_count;
    logic        timeout_err;

    always #5 clk = ~clk;

    des_block_loader #(.PAD_BYTE(PAD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .key_in(key_in), .key_load(key_load),
        .plain_text(plain_text), .key_out(key_out), .start(start),
        .core_valid(core_valid), .busy(busy), .blk_count(blk_count),
        .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0; s_last = 1'b0; key_load = 1'b0; core_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {60'd0, s_ready, start, busy, timeout_err}, 64'h8);
        chk({tag, "_blk"}, 64'(blk_count), 64'd0);
        chk({tag, "_pt"},  plain_text, 64'd0);
        chk({tag, "_key"}, key_out, 64'd0);
    endtask

    task automatic assert_reset(input string tag);
        rst_n = 1'b0;
        idle();
        #1;
        chk_reset(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        s_valid = 1'b1; s_data = d; s_last = l;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // ctl = {s_ready, start, busy, timeout_err}
    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        kl;
        logic [63:0] k;
        logic        cv;
        logic [3:0]  ctl;
        logic [15:0] blk;
        logic [63:0] pt;
        logic [63:0] ko;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic kl, input logic [63:0] k, input logic cv,
                                input logic [3:0] ctl, input logic [15:0] blk,
                                input logic [63:0] pt, input logic [63:0] ko);
        return '{v, d, l, kl, k, cv, ctl, blk, pt, ko};
    endfunction

    vec_t tbl [19];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          nwait;
        logic [7:0]  qd[$];
        logic        ql[$];
        logic [63:0] qb[$];
        logic [63:0] mkey, blkv;
        logic [7:0]  b;
        int          pos, len, cvc, nexp, nstart, exp_cnt;
        logic        cur, acc;

        tbl[0]  = mk(0, 8'h00, 0, 1, K1, 0, 4'b1000, 16'd0, 64'h0, K1);
        tbl[1]  = mk(1, 8'h01, 0, 0, 0,  0, 4'b1000, 16'd0, 64'h0100000000000000, K1);
        tbl[2]  = mk(1, 8'h23, 0, 0, 0,  0, 4'b1000, 16'd0, 64'h0123000000000000, K1);
        tbl[3]  = mk(1, 8'h45, 0, 0, 0,  0, 4'b1000, 16'd0, 64'h0123450000000000, K1);
        tbl[4]  = mk(1, 8'h67, 0, 0, 0,  0, 4'b1000, 16'd0, 64'h0123456700000000, K1);
        tbl[5]  = mk(1, 8'h89, 0, 0, 0,  0, 4'b1000, 16'd0, 64'h0123456789000000, K1);
        tbl[6]  = mk(1, 8'hAB, 0, 0, 0,  0, 4'b1000, 16'd0, 64'h0123456789AB0000, K1);
        tbl[7]  = mk(1, 8'hCD, 0, 0, 0,  0, 4'b1000, 16'd0, 64'h0123456789ABCD00, K1);
        tbl[8]  = mk(1, 8'hEF, 1, 0, 0,  0, 4'b0110, 16'd1, 64'h0123456789ABCDEF, K1);
        tbl[9]  = mk(0, 8'h00, 0, 0, 0,  0, 4'b0010, 16'd1, 64'h0123456789ABCDEF, K1);
        tbl[10] = mk(0, 8'h00, 0, 0, 0,  1, 4'b1000, 16'd1, 64'h0123456789ABCDEF, K1);
        tbl[11] = mk(1, 8'hAA, 0, 0, 0,  0, 4'b1000, 16'd1, 64'hAA00000000000000, K1);
        tbl[12] = mk(1, 8'hBB, 0, 0, 0,  0, 4'b1000, 16'd1, 64'hAABB000000000000, K1);
        tbl[13] = mk(1, 8'hCC, 1, 0, 0,  0, 4'b0110, 16'd2, 64'hAABBCC0000000000, K1);
        tbl[14] = mk(0, 8'h00, 0, 1, K3, 0, 4'b0010, 16'd2, 64'hAABBCC0000000000, K1);
        tbl[15] = mk(0, 8'h00, 0, 1, K2, 0, 4'b0010, 16'd2, 64'hAABBCC0000000000, K1);
        tbl[16] = mk(0, 8'h00, 0, 0, 0,  1, 4'b1000, 16'd2, 64'hAABBCC0000000000, K2);
        tbl[17] = mk(1, 8'h11, 0, 0, 0,  1, 4'b1000, 16'd2, 64'h1100000000000000, K2);
        tbl[18] = mk(0, 8'h22, 1, 0, 0,  0, 4'b1000, 16'd2, 64'h1100000000000000, K2);

        // Reset state while rst_n is held low
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l;
            key_load = tbl[i].kl; key_in = tbl[i].k; core_valid = tbl[i].cv;
            tick();
            chk($sformatf("row%0d_ctl", i), {60'd0, s_ready, start, busy, timeout_err}, 64'(tbl[i].ctl));
            chk($sformatf("row%0d_blk", i), 64'(blk_count), 64'(tbl[i].blk));
            chk($sformatf("row%0d_pt", i), plain_text, tbl[i].pt);
            chk($sformatf("row%0d_key", i), key_out, tbl[i].ko);
        end
        idle();

        // Watchdog: complete the block begun with 0x11, then starve the core
        send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        chk("tmo_start", 64'(start), 64'd1);
        chk("tmo_pt", plain_text, 64'h1122334455667788);
        tick();
        nwait = 0;
        for (int c = 0; c < 200 && busy; c++) begin
            nwait++;
            tick();
        end
        chk("tmo_wait_cycles", 64'(nwait), 64'd64);
        chk("tmo_ctl", {60'd0, s_ready, start, busy, timeout_err}, 64'h9);

        // Sticky flag survives a normal block
        send_byte(8'h5A, 1);
        tick();
        core_valid = 1'b1;
        tick();
        core_valid = 1'b0;
        chk("sticky_ctl", {60'd0, s_ready, start, busy, timeout_err}, 64'h9);
        chk("sticky_pt", plain_text, 64'h5A00000000000000);

        // Reset in the middle of a block
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        assert_reset("rst_fill");
        send_byte(8'hF0, 0); send_byte(8'hE1, 0); send_byte(8'hD2, 0); send_byte(8'hC3, 0);
        send_byte(8'hB4, 0); send_byte(8'hA5, 0); send_byte(8'h96, 0); send_byte(8'h87, 0);
        chk("fresh_start", 64'(start), 64'd1);
        chk("fresh_pt", plain_text, 64'hF0E1D2C3B4A59687);
        chk("fresh_blk", 64'(blk_count), 64'd1);
        tick();
        chk("midwait_busy", 64'(busy), 64'd1);
        assert_reset("rst_wait");

        // core_valid on the final WAIT cycle beats the watchdog
        for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h40), 0);
        chk("race_start", 64'(start), 64'd1);
        tick();
        for (int c = 1; c < 64; c++) tick();
        chk("race_still_wait", 64'(busy), 64'd1);
        core_valid = 1'b1;
        tick();
        core_valid = 1'b0;
        chk("race_ctl", {60'd0, s_ready, start, busy, timeout_err}, 64'h8);

        // Randomized stream against a block-level model
        assert_reset("rst_rand");
        for (int m = 0; m < 40; m++) begin
            len = $urandom_range(1, 20);
            pos = 0;
            blkv = {8{PAD}};
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                qd.push_back(b);
                ql.push_back(j == len - 1);
                blkv[63-8*pos -: 8] = b;
                pos++;
                if (pos == 8 || j == len - 1) begin
                    qb.push_back(blkv);
                    blkv = {8{PAD}};
                    pos = 0;
                end
            end
        end
        nexp = qb.size();
        mkey = 64'd0; cvc = 0; nstart = 0; exp_cnt = 0; cur = 1'b0; acc = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (!acc && !start && qd.size() == 0 && qb.size() == 0 && cvc == 0) break;
            if (acc) begin
                void'(qd.pop_front());
                void'(ql.pop_front());
                cur = 1'b0;
            end
            if (start) begin
                nstart++;
                exp_cnt++;
                if (qb.size() == 0) chk("rnd_extra_start", 64'd1, 64'd0);
                else chk("rnd_pt", plain_text, qb.pop_front());
                chk("rnd_key", key_out, mkey);
                chk("rnd_blk", 64'(blk_count), 64'(16'(exp_cnt)));
            end
            core_valid = 1'b0;
            if (cvc > 0) begin
                cvc--;
                if (cvc == 0) core_valid = 1'b1;
            end
            if (start) cvc = $urandom_range(1, 4);
            key_load = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                key_in = {$urandom, $urandom};
                key_load = 1'b1;
                mkey = key_in;
            end
            if (!cur && qd.size() > 0 && $urandom_range(0, 3) != 0) cur = 1'b1;
            s_valid = cur;
            if (cur) begin
                s_data = qd[0];
                s_last = ql[0];
            end else begin
                s_data = 8'($urandom);
                s_last = 1'($urandom);
            end
            acc = cur && s_ready;
            tick();
        end
        idle();
        chk("rnd_blocks", 64'(nstart), 64'(nexp));
        chk("rnd_bytes_left", 64'(qd.size()), 64'd0);
        chk("rnd_timeout", 64'(timeout_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_block_loader.md
Name: des_block_loader

Overview:
- Upstream feeder for the DES encryption core.
- Accepts plaintext as a byte stream on a valid/ready handshake, packs 8 bytes into a 64-bit block, and holds the round key.
- Issues a one-cycle start pulse to the core and holds block and key stable until the core reports completion.
- Pads short final blocks and flags a hung core with a watchdog timeout.

Parameters:
- PAD_BYTE, 8'h00, fill value for unreceived bytes of a block closed early by s_last.
- TIMEOUT, 64, maximum WAIT cycles before the core is declared hung (must be ≥ 2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  8  plaintext byte.
- s_valid  input  1  s_data is valid.
- s_last  input  1  current byte ends the message; close the block now.
- s_ready  output  1  loader accepts a byte this cycle.
- key_in  input  64  new DES key.
- key_load  input  1  one-cycle strobe to load key_in.
- plain_text  output  64  block to core; first accepted byte occupies [63:56].
- key_out  output  64  key to core.
- start  output  1  one-cycle launch pulse to core.
- core_valid  input  1  core result-valid (dat_valid).
- busy  output  1  high in LAUNCH and WAIT.
- blk_count  output  16  blocks launched, wraps 16'hFFFF→0.
- timeout_err  output  1  sticky hang flag.

Behaviour:
- Reset (async, any state): state=FILL, byte_cnt=0, plain_text=0, key_out=0, key_pending=0, start=0, blk_count=0, timeout_err=0, wd_cnt=0.
- s_ready = (state==FILL), combinational from state only. A byte is accepted when s_valid && s_ready.
- FILL:
  - Accepted byte n (byte_cnt=n, 0..7) is written to plain_text[63-8n -: 8]; byte_cnt increments.
  - At the start of each new block, plain_text is first reset to all PAD_BYTE; the load order does not matter as long as padding results.
  - Accepting byte 7, or any byte with s_last=1, moves to LAUNCH next cycle and resets byte_cnt to 0.
  - s_last with byte_cnt=k (0..6) gives bytes k+1..7 = PAD_BYTE.
  - s_last on byte 7 behaves identically to a normal full block.
- LAUNCH: lasts exactly 1 cycle. start=1 (registered output) and blk_count increments. Next state is WAIT, with wd_cnt cleared.
- WAIT:
  - On core_valid=1, go to FILL next cycle; s_ready rises on that cycle.
  - Otherwise wd_cnt increments. When wd_cnt reaches TIMEOUT-1 without core_valid, timeout_err is set to 1 and the state goes to FILL.
  - If core_valid and the timeout terminal count occur in the same cycle, core_valid wins and timeout_err is not set.
- core_valid is ignored in FILL and LAUNCH.
- timeout_err is cleared only by reset.
- plain_text and key_out are unchanged from the LAUNCH cycle until the cycle after leaving WAIT.
- Minimum block period is 8 byte cycles + 1 LAUNCH + core latency + 1.
- key_load:
  - In FILL: key_out <= key_in next cycle, and any pending key is discarded.
  - In LAUNCH/WAIT: key_in is captured into a pending register and key_pending is set. A later key_load overwrites the pending value.
  - On the WAIT→FILL transition, a pending key is copied to key_out and key_pending cleared, so it is in effect before the next start.
- busy = (state==LAUNCH || state==WAIT).
- Bytes presented while s_ready=0 are not consumed; the source must hold them.
- s_last with s_valid=0 has no effect.

Test Plan:
- Reset, key_load key_in=64'h133457799BBCDFF1, stream 01 23 45 67 89 AB CD EF (last on EF) -> one start pulse. In that cycle: plain_text=64'h0123456789ABCDEF, key_out=64'h133457799BBCDFF1, blk_count=1, s_ready=0 until the cycle after core_valid.
- Stream AA BB CC with s_last on CC, PAD_BYTE=8'h00 -> plain_text=64'hAABBCC0000000000 at start; next block begins at [63:56].
- key_load 64'h0E329232EA6D0D73 in WAIT -> key_out unchanged until core_valid, then equals the new key in the first FILL cycle. A second load in WAIT -> only the last value is applied.
- Hold core_valid=0 after start with TIMEOUT=64 -> 64 WAIT cycles elapse, timeout_err=1 sticky, state FILL, s_ready=1. core_valid on the 64th WAIT cycle instead -> timeout_err stays 0.
- Assert rst_n=0 mid-WAIT and mid-FILL (byte_cnt=4) -> all outputs return to reset values immediately. The next 8 bytes form a fresh block starting at [63:56].
- Launch 65536 blocks back-to-back with core_valid two cycles after start -> blk_count wraps to 0. No byte is dropped or duplicated, and s_valid is held across s_ready=0.
